// File: rtl/issue_queue.sv
// Age-ordered collapsing issue queue with broadcast wakeup and oldest-ready select.
// Optional same-cycle enqueue-to-issue bypass: define ISSUE_QUEUE_ENQ_BYPASS_EN.
module issue_queue #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned D_TAGW   = 5,
    parameter int unsigned S_TAGW   = 3,
    parameter int unsigned ROB_W    = 4,
    parameter int unsigned OP_W     = 4,
    parameter int unsigned IMM_W    = 16,
    parameter int unsigned NUM_WAKE = 2,
    localparam int unsigned OCC_W   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [ROB_W-1:0]             enq_rob_addr,
    input  logic [OP_W-1:0]              enq_alu_op,
    input  logic [IMM_W-1:0]             enq_immdt,
    input  logic [D_TAGW-1:0]            enq_ra_addr,
    input  logic                         enq_ra_rdy,
    input  logic                         enq_use_rt,
    input  logic [D_TAGW-1:0]            enq_rt_addr,
    input  logic                         enq_rt_rdy,
    input  logic                         enq_write_dst,
    input  logic [D_TAGW-1:0]            enq_rw_addr,
    input  logic [S_TAGW-1:0]            enq_rs_addr,
    input  logic [NUM_WAKE-1:0]          wake_valid,
    input  logic [NUM_WAKE*D_TAGW-1:0]   wake_addr,
    output logic                         iss_valid,
    input  logic                         iss_ready,
    output logic [ROB_W-1:0]             iss_rob_addr,
    output logic [OP_W-1:0]              iss_alu_op,
    output logic [IMM_W-1:0]             iss_immdt,
    output logic [D_TAGW-1:0]            iss_ra_addr,
    output logic                         iss_use_rt,
    output logic [D_TAGW-1:0]            iss_rt_addr,
    output logic                         iss_write_dst,
    output logic [D_TAGW-1:0]            iss_rw_addr,
    output logic [S_TAGW-1:0]            iss_rs_addr,
    output logic [OCC_W-1:0]             occupancy
);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ROB_W-1:0]  rob;
        logic [OP_W-1:0]   op;
        logic [IMM_W-1:0]  imm;
        logic [D_TAGW-1:0] ra;
        logic              use_rt;
        logic [D_TAGW-1:0] rt;
        logic              wd;
        logic [D_TAGW-1:0] rw;
        logic [S_TAGW-1:0] rs;
    } entry_t;

    function automatic logic f_wake(input logic [D_TAGW-1:0] tag,
                                    input logic [NUM_WAKE-1:0] vld,
                                    input logic [NUM_WAKE*D_TAGW-1:0] addr);
        logic hit;
        hit = 1'b0;
        for (int unsigned p = 0; p < NUM_WAKE; p++)
            if (vld[p] && addr[p*D_TAGW +: D_TAGW] == tag) hit = 1'b1;
        return hit;
    endfunction

    entry_t            r_ent [DEPTH];
    logic [DEPTH-1:0]  r_ra_rdy;
    logic [DEPTH-1:0]  r_rt_rdy;
    logic [OCC_W-1:0]  r_occ;

    entry_t            w_enq_ent;
    entry_t            w_iss_ent;
    entry_t            w_nxt_ent [DEPTH];
    logic [DEPTH-1:0]  w_elig, w_ra_upd, w_rt_upd, w_nxt_ra, w_nxt_rt;
    logic              w_any, w_byp, w_iss_valid, w_stored_fire;
    logic              w_enq_ready, w_enq_fire, w_enq_wr;
    logic              w_enq_ra_rdy, w_enq_rt_rdy;
    logic [IDX_W-1:0]  w_sel;
    logic [OCC_W-1:0]  w_wr_idx, w_occ_nxt;

    assign w_enq_ent = '{rob: enq_rob_addr, op: enq_alu_op, imm: enq_immdt,
                         ra: enq_ra_addr, use_rt: enq_use_rt, rt: enq_rt_addr,
                         wd: enq_write_dst, rw: enq_rw_addr, rs: enq_rs_addr};

    // Eligibility uses registered rdy bits; wake-updated bits land next edge.
    always_comb begin
        w_any    = 1'b0;
        w_sel    = '0;
        w_elig   = '0;
        w_ra_upd = '0;
        w_rt_upd = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_elig[i]   = (OCC_W'(i) < r_occ) && r_ra_rdy[i] && (r_rt_rdy[i] || !r_ent[i].use_rt);
            w_ra_upd[i] = r_ra_rdy[i] | f_wake(r_ent[i].ra, wake_valid, wake_addr);
            w_rt_upd[i] = r_rt_rdy[i] | f_wake(r_ent[i].rt, wake_valid, wake_addr);
            if (w_elig[i] && !w_any) begin
                w_any = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
    end

    assign w_enq_ready  = !rst && (r_occ < OCC_W'(DEPTH));
    assign w_enq_fire   = enq_valid && w_enq_ready && !flush;
    assign w_enq_ra_rdy = enq_ra_rdy | f_wake(enq_ra_addr, wake_valid, wake_addr);
    assign w_enq_rt_rdy = enq_rt_rdy | f_wake(enq_rt_addr, wake_valid, wake_addr);

`ifdef ISSUE_QUEUE_ENQ_BYPASS_EN
    assign w_byp = !w_any && w_enq_fire && w_enq_ra_rdy && (w_enq_rt_rdy || !enq_use_rt);
`else
    assign w_byp = 1'b0;
`endif

    assign w_iss_valid   = !rst && !flush && (w_any || w_byp);
    assign w_stored_fire = w_iss_valid && iss_ready && w_any;
    // A bypassed op that is accepted the same cycle never occupies a slot.
    assign w_enq_wr      = w_enq_fire && !(w_byp && iss_ready);
    assign w_wr_idx      = r_occ - OCC_W'(w_stored_fire);
    assign w_occ_nxt     = r_occ + OCC_W'(w_enq_wr) - OCC_W'(w_stored_fire);

    always_comb begin
        if (!w_iss_valid) w_iss_ent = '0;
        else if (w_any)   w_iss_ent = r_ent[w_sel];
        else              w_iss_ent = w_enq_ent;
    end

    always_comb begin
        w_nxt_ra = w_ra_upd;
        w_nxt_rt = w_rt_upd;
        for (int unsigned i = 0; i < DEPTH; i++) w_nxt_ent[i] = r_ent[i];
        if (w_stored_fire) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (IDX_W'(i) >= w_sel) begin
                    w_nxt_ent[i] = r_ent[i+1];
                    w_nxt_ra[i]  = w_ra_upd[i+1];
                    w_nxt_rt[i]  = w_rt_upd[i+1];
                end
            end
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_enq_wr && OCC_W'(i) == w_wr_idx) begin
                w_nxt_ent[i] = w_enq_ent;
                w_nxt_ra[i]  = w_enq_ra_rdy;
                w_nxt_rt[i]  = w_enq_rt_rdy;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ    <= '0;
            r_ra_rdy <= '0;
            r_rt_rdy <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ    <= w_occ_nxt;
            r_ra_rdy <= w_nxt_ra;
            r_rt_rdy <= w_nxt_rt;
            for (int unsigned i = 0; i < DEPTH; i++) r_ent[i] <= w_nxt_ent[i];
        end
    end

    assign enq_ready     = w_enq_ready;
    assign iss_valid     = w_iss_valid;
    assign iss_rob_addr  = w_iss_ent.rob;
    assign iss_alu_op    = w_iss_ent.op;
    assign iss_immdt     = w_iss_ent.imm;
    assign iss_ra_addr   = w_iss_ent.ra;
    assign iss_use_rt    = w_iss_ent.use_rt;
    assign iss_rt_addr   = w_iss_ent.rt;
    assign iss_write_dst = w_iss_ent.wd;
    assign iss_rw_addr   = w_iss_ent.rw;
    assign iss_rs_addr   = w_iss_ent.rs;
    assign occupancy     = r_occ;

endmodule
